// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op codes,
// FSM state encoding, default datapath width and small op-decode helpers.
package muldiv_defs;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One iteration of the unsigned mul/div datapath: a shift-add multiply step
// or a restoring-subtract divide step over the {acc, q} working pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    acc_nxt = acc;
    q_nxt   = q;
    sum     = {1'b0, acc} + {1'b0, (q[0] ? b : {WIDTH{1'b0}})};
    shifted = {acc, q[WIDTH-1]};
    // When the trial subtract succeeds the difference is below b, so the
    // low WIDTH bits are exact.
    sub     = shifted[WIDTH-1:0] - b;
    if (is_div) begin
      if (shifted >= {1'b0, b}) begin
        acc_nxt = sub;
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv
  import muldiv_defs::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] q_nxt;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  assign accept = start & ~flush & ~busy & (state == S_IDLE);
  assign a_neg  = is_signed_op(op) & srca[WIDTH-1];
  assign b_neg  = is_signed_op(op) & srcb[WIDTH-1];
  assign a_mag  = a_neg ? -srca : srca;
  assign b_mag  = b_neg ? -srcb : srcb;

  // Sign correction on the unsigned result; a zero divisor forces an
  // all-ones quotient while the remainder naturally reproduces srca.
  assign prod_s = neg_q ? -{acc, q} : {acc, q};
  assign quo_s  = dz ? {WIDTH{1'b1}} : (neg_q ? -q : q);
  assign rem_s  = neg_r ? -acc : acc;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .q       (q),
    .b       (b),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  // NOTE: reset is synchronous, sampled inside the clocked block, and all
  // state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      acc    <= '0;
      q      <= '0;
      b      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MTHI) begin
              hi <= srca;
            end else if (op == OP_MTLO) begin
              lo <= srca;
            end else if (is_muldiv(op)) begin
              is_div <= is_div_op(op);
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              dz     <= is_div_op(op) & (srcb == '0);
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_RUN;
              if (is_div_op(op)) begin
                q <= a_mag;
                b <= b_mag;
              end else begin
`ifdef MULDIV_FAST_MUL_EN
                acc   <= fast_prod[2*WIDTH-1:WIDTH];
                q     <= fast_prod[WIDTH-1:0];
                state <= S_FIX;
`else
                q <= b_mag;
                b <= a_mag;
`endif
              end
            end
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            hi <= rem_s;
            lo <= quo_s;
          end else begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
